mem_word_loader: RTL and testbench

Debug write path into the PipelineCPU data memory, the counterpart of the board-level address/readback display path. Assembles 32-bit words from four successive 8-bit switch entries, each committed by a debounced button, then drives a single-word write request to the memory with a request/acknowledge handshake. Sits in the board top between the debounced button/switch inputs and the CPU debug write port. Tracks an auto-incrementing write address and reports progress on LEDs.

---
 rtl/mem_word_loader.sv | 135 +++++++++++++
 tb/tb_mem_word_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_word_loader
// Brief    : Packs four button-committed switch bytes into a 32-bit word and
//            writes it to data memory via req/ack, auto-incrementing address.
// Revision : 1.0
// ============================================================================
module mem_word_loader #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_byte_btn,
    input  logic [7:0]  i_data_in,
    input  logic [7:0]  i_addr_in,
    input  logic        i_clear,
    input  logic        i_wr_ack,
    output logic        o_wr_req,
    output logic [7:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [1:0]  o_byte_cnt,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [15:0] c_TMO_LOAD = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_btn_q;
    logic        r_seq_start;
    logic        r_wr_req;
    logic [7:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic [1:0]  r_byte_cnt;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_tmo_cnt;
    logic        w_commit;

    assign w_commit = i_byte_btn & ~r_btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_btn_q     <= 1'b0;
            r_seq_start <= 1'b1;
            r_wr_req    <= 1'b0;
            r_wr_addr   <= 8'h00;
            r_wr_data   <= 32'h0000_0000;
            r_byte_cnt  <= 2'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_tmo_cnt   <= 16'd0;
        end else begin
            r_btn_q <= i_byte_btn;
            r_done  <= 1'b0;
            // Clear wins over any commit or ack arriving in the same cycle.
            if (i_clear) begin
                r_state     <= S_IDLE;
                r_wr_req    <= 1'b0;
                r_byte_cnt  <= 2'd0;
                r_seq_start <= 1'b1;
                r_err       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_commit) begin
                            if (r_seq_start) begin
                                r_wr_addr <= i_addr_in;
                            end
                            r_wr_data[31:24] <= i_data_in;
                            r_byte_cnt       <= 2'd1;
                            r_seq_start      <= 1'b0;
                            r_state          <= S_COLLECT;
                        end
                    end
                    S_COLLECT: begin
                        if (w_commit) begin
                            case (r_byte_cnt)
                                2'd1:    r_wr_data[23:16] <= i_data_in;
                                2'd2:    r_wr_data[15:8]  <= i_data_in;
                                default: r_wr_data[7:0]   <= i_data_in;
                            endcase
                            if (r_byte_cnt == 2'd3) begin
                                r_byte_cnt <= 2'd0;
                                r_wr_req   <= 1'b1;
                                r_tmo_cnt  <= c_TMO_LOAD;
                                r_state    <= S_WRITE;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                            end
                        end
                    end
                    S_WRITE: begin
                        // Loading TIMEOUT-1 and expiring at zero keeps req high
                        // for exactly ACK_TIMEOUT cycles.
                        if (i_wr_ack) begin
                            r_wr_req  <= 1'b0;
                            r_done    <= 1'b1;
                            r_wr_addr <= r_wr_addr + 8'd1;
                            r_state   <= S_IDLE;
                        end else if (r_tmo_cnt == 16'd0) begin
                            r_wr_req <= 1'b0;
                            r_err    <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt - 16'd1;
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_wr_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_wr_req   = r_wr_req;
    assign o_busy     = r_wr_req;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_byte_cnt = r_byte_cnt;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_word_loader
// Brief    : Directed self-checking bench for mem_word_loader.
// Revision : 1.0
// ============================================================================
module tb_mem_word_loader;

    logic        clk;
    logic        rst_n;
    logic        r_byte_btn;
    logic [7:0]  r_data_in;
    logic [7:0]  r_addr_in;
    logic        r_clear;
    logic        r_wr_ack;
    logic        w_wr_req;
    logic [7:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [1:0]  w_byte_cnt;
    logic        w_busy;
    logic        w_done;
    logic        w_err;

    int n_checks;
    int n_fail;

    mem_word_loader #(.ACK_TIMEOUT(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_byte_btn (r_byte_btn),
        .i_data_in  (r_data_in),
        .i_addr_in  (r_addr_in),
        .i_clear    (r_clear),
        .i_wr_ack   (r_wr_ack),
        .o_wr_req   (w_wr_req),
        .o_wr_addr  (w_wr_addr),
        .o_wr_data  (w_wr_data),
        .o_byte_cnt (w_byte_cnt),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_err      (w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] b);
        r_data_in  = b;
        r_byte_btn = 1'b1;
        tick();
        r_byte_btn = 1'b0;
        tick();
    endtask

    task automatic ack_write();
        r_wr_ack = 1'b1;
        tick();
        r_wr_ack = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  saw_done;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        r_byte_btn = 1'b0;
        r_data_in  = 8'h00;
        r_addr_in  = 8'h00;
        r_clear    = 1'b0;
        r_wr_ack   = 1'b0;
        tick();
        tick();
        check_val("rst_wr_req",   32'(w_wr_req),   32'd0);
        check_val("rst_busy",     32'(w_busy),     32'd0);
        check_val("rst_wr_addr",  32'(w_wr_addr),  32'h00);
        check_val("rst_wr_data",  w_wr_data,       32'h0);
        check_val("rst_byte_cnt", 32'(w_byte_cnt), 32'd0);
        check_val("rst_done_err", {30'd0, w_done, w_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // First word at 0x10, acked three cycles into the write.
        r_addr_in = 8'h10;
        press(8'hDE);
        check_val("cnt_after_1", 32'(w_byte_cnt), 32'd1);
        press(8'hAD);
        press(8'hBE);
        press(8'hEF);
        check_val("w1_req",  32'(w_wr_req),  32'd1);
        check_val("w1_busy", 32'(w_busy),    32'd1);
        check_val("w1_addr", 32'(w_wr_addr), 32'h10);
        check_val("w1_data", w_wr_data,      32'hDEADBEEF);
        check_val("w1_cnt",  32'(w_byte_cnt), 32'd0);
        tick();
        ack_write();
        check_val("w1_done",     32'(w_done),    32'd1);
        check_val("w1_req_drop", 32'(w_wr_req),  32'd0);
        check_val("w1_busy_low", 32'(w_busy),    32'd0);
        check_val("w1_addr_inc", 32'(w_wr_addr), 32'h11);
        tick();
        check_val("w1_done_pulse", 32'(w_done), 32'd0);

        // Second word ignores the new addr_in and continues at 0x11.
        r_addr_in = 8'h40;
        press(8'h01);
        press(8'h02);
        press(8'h03);
        press(8'h04);
        check_val("w2_addr", 32'(w_wr_addr), 32'h11);
        check_val("w2_data", w_wr_data,      32'h01020304);
        ack_write();
        check_val("w2_addr_inc", 32'(w_wr_addr), 32'h12);

        // Unacknowledged write times out after exactly 16 request cycles.
        press(8'hA1);
        press(8'hA2);
        press(8'hA3);
        r_data_in  = 8'hA4;
        r_byte_btn = 1'b1;
        tick();
        r_byte_btn = 1'b0;
        cyc      = 0;
        saw_done = 0;
        while (w_wr_req && cyc < 100) begin
            cyc++;
            if (w_done) saw_done = 1;
            tick();
        end
        if (w_done) saw_done = 1;
        check_val("tmo_cycles", 32'(cyc),       32'd16);
        check_val("tmo_err",    32'(w_err),     32'd1);
        check_val("tmo_nodone", 32'(saw_done),  32'd0);
        check_val("tmo_addr",   32'(w_wr_addr), 32'h12);
        r_clear = 1'b1;
        tick();
        r_clear = 1'b0;
        check_val("clr_err", 32'(w_err), 32'd0);

        // Partial word discarded by clear; new sequence restarts at addr_in and wraps.
        press(8'hAA);
        press(8'hBB);
        check_val("part_cnt", 32'(w_byte_cnt), 32'd2);
        r_clear = 1'b1;
        tick();
        r_clear = 1'b0;
        check_val("part_clr_cnt", 32'(w_byte_cnt), 32'd0);
        r_addr_in = 8'hFF;
        press(8'h11);
        press(8'h22);
        press(8'h33);
        press(8'h44);
        check_val("wrap_addr", 32'(w_wr_addr), 32'hFF);
        check_val("wrap_data", w_wr_data,      32'h11223344);
        ack_write();
        check_val("wrap_addr_inc", 32'(w_wr_addr), 32'h00);

        // A long hold commits one byte only; presses during WRITE are dropped.
        r_data_in  = 8'h55;
        r_byte_btn = 1'b1;
        repeat (100) tick();
        check_val("hold_cnt", 32'(w_byte_cnt), 32'd1);
        r_byte_btn = 1'b0;
        tick();
        press(8'h66);
        press(8'h77);
        press(8'h88);
        check_val("w5_req", 32'(w_wr_req), 32'd1);
        press(8'h99);
        check_val("drop_cnt",  32'(w_byte_cnt), 32'd0);
        check_val("drop_data", w_wr_data,       32'h55667788);
        check_val("drop_req",  32'(w_wr_req),   32'd1);

        // Asynchronous reset in the middle of a write.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_req",  32'(w_wr_req),   32'd0);
        check_val("arst_busy", 32'(w_busy),     32'd0);
        check_val("arst_done", 32'(w_done),     32'd0);
        check_val("arst_addr", 32'(w_wr_addr),  32'h00);
        check_val("arst_data", w_wr_data,       32'h0);
        check_val("arst_err",  32'(w_err),      32'd0);
        check_val("arst_cnt",  32'(w_byte_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
